// File: rtl/i2s_frame_sched.sv
// i2s_frame_sched: FIFO-buffered I2S transmitter that starts one word per LR edge with a one-bit delay
module i2s_frame_sched #(
  parameter int DATA_W    = 24,
  parameter int DEPTH     = 4,
  parameter int LOW_WATER = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    lr_clk,
  input  logic                    bit_tick,
  output logic                    serial,
  output logic [$clog2(DEPTH):0]  fill,
  output logic                    irq,
  output logic                    underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LOW = (AW+1)'(LOW_WATER);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] sreg;
  logic [BW-1:0] bcnt;
  logic lr_s1, lr_s2, lr_prev;
  logic [2:0] prime;
  logic frame_start, push, pop, tick, shift_en, serial_d;
  // prime[2] is set only once lr_prev holds a real synchronized sample, so the first level is a baseline
  assign frame_start = prime[2] && (lr_s2 != lr_prev);
  assign tick = bit_tick && !frame_start;
  assign in_ready = fill != FULL;
  assign push = in_valid && in_ready;
  assign pop = frame_start && fill != '0;
  // two-flop synchronizer for lr_clk plus edge-history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_s1 <= 1'b0;
      lr_s2 <= 1'b0;
      lr_prev <= 1'b0;
      prime <= '0;
    end else begin
      lr_s1 <= lr_clk;
      lr_s2 <= lr_s1;
      lr_prev <= lr_s2;
      prime <= {prime[1:0], 1'b1};
    end
  end
  // FIFO pointers, occupancy, refill request and underrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      irq <= 1'b1;
      underrun <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
      irq <= fill <= LOW;
      underrun <= frame_start && fill == '0;
    end
  end
  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // FSM next state: any frame edge restarts the frame, truncating whatever was in flight
  always_comb begin
    state_d = state;
    if (frame_start) state_d = DELAY;
    else if (tick && state == DELAY) state_d = SHIFT;
    else if (tick && state == SHIFT && bcnt == LAST) state_d = PAD;
  end
  // FSM outputs: next serial bit and shift enable
  always_comb begin
    shift_en = tick && state == SHIFT;
    serial_d = frame_start ? 1'b0 : shift_en ? sreg[DATA_W-1] : tick ? 1'b0 : serial;
  end
  // shift register, bit counter and registered serial line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      bcnt <= '0;
      serial <= 1'b0;
    end else begin
      if (frame_start) sreg <= pop ? mem[rd_ptr] : '0;
      else if (shift_en) sreg <= sreg << 1;
      bcnt <= frame_start ? '0 : shift_en ? bcnt + 1'b1 : bcnt;
      serial <= serial_d;
    end
  end
endmodule

// File: tb/tb_i2s_frame_sched.sv
// tb_i2s_frame_sched: scoreboard bench for the I2S frame scheduler
module tb_i2s_frame_sched;
  localparam int LW = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic in_ready;
  logic lr_clk = 1'b0;
  logic bit_tick = 1'b0;
  logic serial;
  logic [2:0] fill;
  logic irq;
  logic underrun;
  int n_run = 0;
  int n_fail = 0;
  logic [23:0] q [$];
  logic [23:0] cur_exp;

  i2s_frame_sched #(.DATA_W(24), .DEPTH(4), .LOW_WATER(LW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .lr_clk(lr_clk), .bit_tick(bit_tick), .serial(serial), .fill(fill), .irq(irq), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [23:0] w);
    int nb;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = w;
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      chk("push_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    nb = q.size();
    q.push_back(w);
    chk("push_fill", fill, q.size());
    chk("push_irq_pre", irq, nb <= LW);
    @(negedge clk);
    chk("push_irq_post", irq, nb + 1 <= LW);
  endtask

  task automatic frame();
    int nb, na;
    bit ur;
    @(negedge clk);
    nb = q.size();
    ur = nb == 0;
    cur_exp = ur ? 24'h0 : q.pop_front();
    na = ur ? 0 : nb - 1;
    lr_clk = ~lr_clk;
    repeat (3) @(negedge clk);
    chk("underrun", underrun, ur);
    chk("fill_pop", fill, na);
    chk("irq_pre", irq, nb <= LW);
    @(negedge clk);
    chk("underrun_end", underrun, 0);
    chk("irq_post", irq, na <= LW);
  endtask

  task automatic do_tick(output logic s);
    @(negedge clk);
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    s = serial;
  endtask

  task automatic send_check(input logic [23:0] w);
    logic s;
    logic [23:0] got;
    got = '0;
    do_tick(s);
    chk("delay_bit", s, 0);
    for (int i = 0; i < 24; i++) begin
      do_tick(s);
      got = {got[22:0], s};
    end
    chk("word", got, w);
    do_tick(s);
    chk("pad_bit", s, 0);
  endtask

  initial begin
    logic s;
    logic ur_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fill", fill, 0);
    chk("rst_irq", irq, 1);
    chk("rst_serial", serial, 0);
    chk("rst_underrun", underrun, 0);
    // basic word
    push(24'hA5A5A5);
    frame();
    send_check(cur_exp);
    // fill to full, fifth held until a frame pops
    push(24'h111111);
    push(24'h222222);
    push(24'h333333);
    push(24'h444444);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_fill", fill, 4);
    fork
      push(24'h555555);
      frame();
    join
    send_check(cur_exp);
    frame();
    send_check(cur_exp);
    frame();
    send_check(cur_exp);
    frame();
    send_check(cur_exp);
    push(24'h666666);
    frame();
    send_check(cur_exp);
    frame();
    send_check(cur_exp);
    // underrun on empty FIFO
    frame();
    send_check(cur_exp);
    chk("underrun_fill", fill, 0);
    // truncation after 10 bits
    push(24'hFFFFFF);
    push(24'h800001);
    frame();
    do_tick(s);
    for (int i = 0; i < 10; i++) do_tick(s);
    chk("trunc_bit", s, 1);
    frame();
    chk("trunc_serial", serial, 0);
    send_check(cur_exp);
    // reset mid-SHIFT with fill=3
    push(24'hFFFFFF);
    push(24'h123456);
    push(24'h654321);
    push(24'hABCDEF);
    frame();
    for (int i = 0; i < 5; i++) do_tick(s);
    chk("pre_rst_serial", s, 1);
    chk("pre_rst_fill", fill, 3);
    @(negedge clk);
    rst_n = 1'b0;
    lr_clk = 1'b1;
    #1;
    chk("mid_rst_serial", serial, 0);
    chk("mid_rst_fill", fill, 0);
    chk("mid_rst_irq", irq, 1);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ur_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ur_seen = ur_seen | underrun;
    end
    chk("baseline_no_frame", ur_seen, 0);
    chk("post_rst_serial", serial, 0);
    push(24'h5A5A5A);
    repeat (4) @(negedge clk);
    chk("baseline_fill", fill, 1);
    frame();
    send_check(cur_exp);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
